// File: rtl/hdmi_video_out_pkg.sv
// ============================================================================
//  Module   : hdmi_video_out_pkg
//  Purpose  : Shared DVI constants: TMDS control tokens, 640x480 timing,
//             encoder disparity width and small helper functions.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hdmi_video_out_pkg;

    localparam logic [9:0] c_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] c_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] c_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] c_TOKEN_11 = 10'b1010101011;

    localparam int c_H_ACTIVE = 640;
    localparam int c_H_FRONT  = 16;
    localparam int c_H_SYNC   = 96;
    localparam int c_H_BACK   = 48;
    localparam int c_V_ACTIVE = 480;
    localparam int c_V_FRONT  = 10;
    localparam int c_V_SYNC   = 2;
    localparam int c_V_BACK   = 33;

    localparam int c_DISP_W = 5;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = c_TOKEN_00;
            2'b01:   t = c_TOKEN_01;
            2'b10:   t = c_TOKEN_10;
            default: t = c_TOKEN_11;
        endcase
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tmds_encoder.sv
// ============================================================================
//  Module   : tmds_encoder
//  Purpose  : Registered DVI 1.0 TMDS encoder, 8-bit data / 2 control bits
//             to one 10-bit symbol per clock.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmds_encoder
    import hdmi_video_out_pkg::*;
#(
    parameter logic [9:0] RESET_Q = c_TOKEN_00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       de,
    input  logic       c0,
    input  logic       c1,
    input  logic [7:0] d,
    output logic [9:0] q
);

    logic [3:0]          w_n1d;
    logic [3:0]          w_n1q;
    logic                w_xnor;
    logic [8:0]          w_qm;
    logic [c_DISP_W-1:0] w_bal;
    logic                w_disp_zero;
    logic                w_disp_pos;
    logic                w_disp_neg;
    logic [9:0]          w_q;
    logic [c_DISP_W-1:0] w_disp_next;
    logic [c_DISP_W-1:0] r_disp;
    logic [9:0]          r_q;

    // Disparity is kept modulo 2^c_DISP_W; only its sign is ever inspected.
    always_comb begin
        w_n1d  = popcount8(d);
        w_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !d[0]);
        w_qm   = 9'd0;
        w_qm[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            w_qm[i] = w_xnor ? ~(w_qm[i-1] ^ d[i]) : (w_qm[i-1] ^ d[i]);
        end
        w_qm[8] = ~w_xnor;
        w_n1q   = popcount8(w_qm[7:0]);
        w_bal   = {w_n1q, 1'b0} - 5'd8;

        w_disp_zero = (r_disp == '0);
        w_disp_neg  = r_disp[c_DISP_W-1];
        w_disp_pos  = !w_disp_zero && !w_disp_neg;

        if (w_disp_zero || (w_n1q == 4'd4)) begin
            w_q         = {~w_qm[8], w_qm[8], w_qm[8] ? w_qm[7:0] : ~w_qm[7:0]};
            w_disp_next = w_qm[8] ? (r_disp + w_bal) : (r_disp - w_bal);
        end else if ((w_disp_pos && (w_n1q > 4'd4)) || (w_disp_neg && (w_n1q < 4'd4))) begin
            w_q         = {1'b1, w_qm[8], ~w_qm[7:0]};
            w_disp_next = r_disp + {{(c_DISP_W-2){1'b0}}, w_qm[8], 1'b0} - w_bal;
        end else begin
            w_q         = {1'b0, w_qm[8], w_qm[7:0]};
            w_disp_next = r_disp - {{(c_DISP_W-2){1'b0}}, ~w_qm[8], 1'b0} + w_bal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= RESET_Q;
            r_disp <= '0;
        end else if (!de) begin
            r_q    <= ctrl_token({c1, c0});
            r_disp <= '0;
        end else begin
            r_q    <= w_q;
            r_disp <= w_disp_next;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/hdmi_video_out.sv
// ============================================================================
//  Module   : hdmi_video_out
//  Purpose  : DVI raster generator reading a 1-bit framebuffer window and
//             emitting three TMDS channels for an external serializer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdmi_video_out
    import hdmi_video_out_pkg::*;
#(
    parameter int         H_ACTIVE   = c_H_ACTIVE,
    parameter int         H_FRONT    = c_H_FRONT,
    parameter int         H_SYNC     = c_H_SYNC,
    parameter int         H_BACK     = c_H_BACK,
    parameter int         V_ACTIVE   = c_V_ACTIVE,
    parameter int         V_FRONT    = c_V_FRONT,
    parameter int         V_SYNC     = c_V_SYNC,
    parameter int         V_BACK     = c_V_BACK,
    parameter int         ADDR_WIDTH = 16,
    parameter int         MIN_X      = 40,
    parameter int         MIN_Y      = 40,
    parameter int         WIDTH      = 256,
    parameter int         HEIGHT     = 200,
    parameter logic [7:0] FG         = 8'hFF,
    parameter logic [7:0] BG         = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_data,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  data_valid,
    output logic [7:0]            pixel,
    output logic                  frame_start,
    output logic [9:0]            tmds_d0,
    output logic [9:0]            tmds_d1,
    output logic [9:0]            tmds_d2
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    logic [11:0]           r_hcnt;
    logic [11:0]           r_vcnt;
    logic                  w_h_wrap;
    logic                  w_v_wrap;
    logic                  w_active;
    logic                  w_hsync;
    logic                  w_vsync;
    logic [11:0]           w_xoff;
    logic [11:0]           w_yoff;
    logic                  w_in_win;
    logic                  w_first;
    logic [ADDR_WIDTH-1:0] w_addr;

    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_s1_active;
    logic                  r_s1_in_win;
    logic                  r_s1_hsync;
    logic                  r_s1_vsync;
    logic                  r_s1_first;

    logic                  r_hsync;
    logic                  r_vsync;
    logic                  r_dv;
    logic [7:0]            r_pixel;
    logic                  r_fs;

    assign w_h_wrap = (r_hcnt == 12'(c_H_TOTAL - 1));
    assign w_v_wrap = (r_vcnt == 12'(c_V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcnt <= 12'd0;
            r_vcnt <= 12'd0;
        end else if (w_h_wrap) begin
            r_hcnt <= 12'd0;
            r_vcnt <= w_v_wrap ? 12'd0 : r_vcnt + 12'd1;
        end else begin
            r_hcnt <= r_hcnt + 12'd1;
        end
    end

    // Offsets wrap to large values left of / above the window, so one
    // unsigned compare per axis covers both edges.
    assign w_active = (r_hcnt < 12'(H_ACTIVE)) && (r_vcnt < 12'(V_ACTIVE));
    assign w_hsync  = !((r_hcnt >= 12'(H_ACTIVE + H_FRONT)) &&
                        (r_hcnt <  12'(H_ACTIVE + H_FRONT + H_SYNC)));
    assign w_vsync  = !((r_vcnt >= 12'(V_ACTIVE + V_FRONT)) &&
                        (r_vcnt <  12'(V_ACTIVE + V_FRONT + V_SYNC)));
    assign w_xoff   = r_hcnt - 12'(MIN_X);
    assign w_yoff   = r_vcnt - 12'(MIN_Y);
    assign w_in_win = w_active && (w_xoff < 12'(WIDTH)) && (w_yoff < 12'(HEIGHT));
    assign w_first  = (r_hcnt == 12'd0) && (r_vcnt == 12'd0);
    assign w_addr   = ADDR_WIDTH'(w_xoff) + ADDR_WIDTH'(w_yoff) * ADDR_WIDTH'(WIDTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_addr   <= '0;
            r_s1_active <= 1'b0;
            r_s1_in_win <= 1'b0;
            r_s1_hsync  <= 1'b1;
            r_s1_vsync  <= 1'b1;
            r_s1_first  <= 1'b0;
        end else begin
            if (w_in_win) begin
                r_rd_addr <= w_addr;
            end
            r_s1_active <= w_active;
            r_s1_in_win <= w_in_win;
            r_s1_hsync  <= w_hsync;
            r_s1_vsync  <= w_vsync;
            r_s1_first  <= w_first;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_dv    <= 1'b0;
            r_pixel <= 8'h00;
            r_fs    <= 1'b0;
        end else begin
            r_hsync <= r_s1_hsync;
            r_vsync <= r_s1_vsync;
            r_dv    <= r_s1_active;
            r_fs    <= r_s1_first;
            if (!r_s1_active) begin
                r_pixel <= 8'h00;
            end else begin
                r_pixel <= (r_s1_in_win && rd_data) ? FG : BG;
            end
        end
    end

    tmds_encoder #(.RESET_Q(c_TOKEN_11)) u_enc0 (
        .clk   (clk),
        .reset (reset),
        .de    (r_dv),
        .c0    (r_hsync),
        .c1    (r_vsync),
        .d     (r_pixel),
        .q     (tmds_d0)
    );

    tmds_encoder #(.RESET_Q(c_TOKEN_00)) u_enc1 (
        .clk   (clk),
        .reset (reset),
        .de    (r_dv),
        .c0    (1'b0),
        .c1    (1'b0),
        .d     (r_pixel),
        .q     (tmds_d1)
    );

    tmds_encoder #(.RESET_Q(c_TOKEN_00)) u_enc2 (
        .clk   (clk),
        .reset (reset),
        .de    (r_dv),
        .c0    (1'b0),
        .c1    (1'b0),
        .d     (r_pixel),
        .q     (tmds_d2)
    );

    assign rd_addr     = r_rd_addr;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign data_valid  = r_dv;
    assign pixel       = r_pixel;
    assign frame_start = r_fs;

endmodule

`default_nettype wire

// File: tb/tb_hdmi_video_out.sv
// ============================================================================
//  Module   : tb_hdmi_video_out
//  Purpose  : Self-checking bench for hdmi_video_out on a reduced raster with
//             a random framebuffer and a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hdmi_video_out;

    localparam int HA = 40, HF = 4, HS = 8, HB = 6;
    localparam int VA = 30, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    // Window deliberately runs past the right edge of the active area.
    localparam int MX = 10, MY = 5, WD = 36, HG = 20;
    localparam int AW = 16;
    localparam logic [7:0] FG = 8'hFF, BG = 8'h00;

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [7:0] pix;
    } st_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] rd_addr;
    logic          rd_data;
    logic          hsync, vsync, data_valid, frame_start;
    logic [7:0]    pixel;
    logic [9:0]    tmds_d0, tmds_d1, tmds_d2;

    bit ram [0:(1<<AW)-1];

    int checks = 0, failures = 0;
    int k = 0;
    int disp [3];
    int exp_addr = 0;
    bit measure = 1'b0;
    int dv_cnt = 0, hs_cnt = 0, dv_fall = -1, hs_fall = -1;
    int fs_first = -1, fs_second = -1;

    always #5 clk = ~clk;

    // rd_addr acts as the RAM address register; data follows within that cycle.
    assign rd_data = ram[rd_addr];

    hdmi_video_out #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .ADDR_WIDTH(AW), .MIN_X(MX), .MIN_Y(MY), .WIDTH(WD), .HEIGHT(HG),
        .FG(FG), .BG(BG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .hsync       (hsync),
        .vsync       (vsync),
        .data_valid  (data_valid),
        .pixel       (pixel),
        .frame_start (frame_start),
        .tmds_d0     (tmds_d0),
        .tmds_d1     (tmds_d1),
        .tmds_d2     (tmds_d2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    function automatic bit in_win(input int h, input int v);
        return (h < HA) && (v < VA) && (h >= MX) && (h < MX + WD) && (v >= MY) && (v < MY + HG);
    endfunction

    function automatic int win_addr(input int h, input int v);
        return (h - MX) + (v - MY) * WD;
    endfunction

    // Expected pixel-stage outputs after kk clock edges since reset release.
    function automatic st_t stage2(input int kk);
        st_t s;
        int  p, h, v;
        s.de = 1'b0; s.hs = 1'b1; s.vs = 1'b1; s.fs = 1'b0; s.pix = 8'h00;
        if (kk >= 2) begin
            p = kk - 2;
            h = p % HT;
            v = (p / HT) % VT;
            s.de = (h < HA) && (v < VA);
            s.hs = !((h >= HA + HF) && (h < HA + HF + HS));
            s.vs = !((v >= VA + VF) && (v < VA + VF + VS));
            s.fs = (h == 0) && (v == 0);
            if (in_win(h, v)) s.pix = ram[win_addr(h, v)] ? FG : BG;
        end
        return s;
    endfunction

    // DVI 1.0 encoder, disparity held as a plain signed integer per channel.
    function automatic logic [9:0] enc(input int ch, input logic de, input logic [1:0] c, input logic [7:0] d);
        logic [8:0] qm;
        logic [9:0] q;
        int n1, ones, zeros;
        bit xn;
        if (!de) begin
            disp[ch] = 0;
            case (c)
                2'b00:   q = 10'b1101010100;
                2'b01:   q = 10'b0010101011;
                2'b10:   q = 10'b0101010100;
                default: q = 10'b1010101011;
            endcase
            return q;
        end
        n1 = $countones(d);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        ones  = $countones(qm[7:0]);
        zeros = 8 - ones;
        if (disp[ch] == 0 || ones == zeros) begin
            q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            disp[ch] = disp[ch] + (qm[8] ? (ones - zeros) : (zeros - ones));
        end else if ((disp[ch] > 0 && ones > zeros) || (disp[ch] < 0 && zeros > ones)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            disp[ch] = disp[ch] + 2 * int'(qm[8]) + zeros - ones;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            disp[ch] = disp[ch] - 2 * int'(!qm[8]) + ones - zeros;
        end
        return q;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, "_hsync"}, 32'(hsync), 32'd1);
        check({tag, "_vsync"}, 32'(vsync), 32'd1);
        check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
        check({tag, "_pixel"}, 32'(pixel), 32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check({tag, "_tmds_d0"}, 32'(tmds_d0), 32'h2AB);
        check({tag, "_tmds_d1"}, 32'(tmds_d1), 32'h354);
        check({tag, "_tmds_d2"}, 32'(tmds_d2), 32'h354);
    endtask

    task automatic cycle_check();
        st_t s, p;
        logic [9:0] e0, e1, e2;
        int h, v;
        @(negedge clk);
        k++;
        h = (k - 1) % HT;
        v = ((k - 1) / HT) % VT;
        if (in_win(h, v)) exp_addr = win_addr(h, v);
        s  = stage2(k);
        p  = stage2(k - 1);
        e0 = enc(0, p.de, {p.vs, p.hs}, p.pix);
        e1 = enc(1, p.de, 2'b00, p.pix);
        e2 = enc(2, p.de, 2'b00, p.pix);
        check("rd_addr", 32'(rd_addr), 32'(exp_addr));
        check("hsync", 32'(hsync), 32'(s.hs));
        check("vsync", 32'(vsync), 32'(s.vs));
        check("data_valid", 32'(data_valid), 32'(s.de));
        check("pixel", 32'(pixel), 32'(s.pix));
        check("frame_start", 32'(frame_start), 32'(s.fs));
        check("tmds_d0", 32'(tmds_d0), 32'(e0));
        check("tmds_d1", 32'(tmds_d1), 32'(e1));
        check("tmds_d2", 32'(tmds_d2), 32'(e2));
        if (measure) begin
            if (k >= 2 && k < 2 + HT) begin
                dv_cnt += int'(data_valid);
                hs_cnt += int'(!hsync);
            end
            if (k > 2 && !data_valid && dv_fall < 0) dv_fall = k;
            if (!hsync && hs_fall < 0) hs_fall = k;
            if (frame_start) begin
                if (fs_first < 0) fs_first = k;
                else if (fs_second < 0) fs_second = k;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) disp[i] = 0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = 1'($urandom);

        repeat (5) @(negedge clk);
        check_reset("reset");

        reset   = 1'b0;
        measure = 1'b1;
        repeat (2 * FRAME + 30 + 10 * HT) cycle_check();
        measure = 1'b0;
        check("line_active_len", 32'(dv_cnt), 32'(HA));
        check("hsync_low_len", 32'(hs_cnt), 32'(HS));
        check("hsync_after_active", 32'(hs_fall - dv_fall), 32'(HF));
        check("frame_start_period", 32'(fs_second - fs_first), 32'(FRAME));

        // Raster now sits at hcnt=30, vcnt=10: reset for one cycle mid-frame.
        reset = 1'b1;
        @(negedge clk);
        check_reset("midreset");
        for (int i = 0; i < (1 << AW); i++) ram[i] = 1'b0;
        for (int i = 0; i < 3; i++) disp[i] = 0;
        k        = 0;
        exp_addr = 0;
        reset    = 1'b0;

        repeat (2) cycle_check();
        check("fs_after_release", 32'(frame_start), 32'd1);
        cycle_check();
        check("zero_first_sym", 32'(tmds_d1), 32'h100);
        cycle_check();
        check("zero_second_sym", 32'(tmds_d1), 32'h3FF);
        repeat (FRAME + 60) cycle_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
